// File: rtl/framebuffer_scanout.sv
// 1-bpp framebuffer scanout: VGA timing, packed-word fetch and pixel serialiser.
// Optional CENTER_AXIS_EN forces the middle visible row to FG_COLOR (reference axis).
module framebuffer_scanout #(
  parameter int           DATA_WIDTH     = 32,
  parameter int           ADDRESS_LENGTH = 14,
  parameter int           H_ACTIVE       = 800,
  parameter int           H_FP           = 24,
  parameter int           H_SYNC         = 72,
  parameter int           H_BP           = 128,
  parameter int           V_ACTIVE       = 600,
  parameter int           V_FP           = 1,
  parameter int           V_SYNC         = 2,
  parameter int           V_BP           = 22,
  parameter bit           SYNC_POL       = 1'b1,
  parameter int           RD_LATENCY     = 1,
  parameter logic [11:0]  FG_COLOR       = 12'hFFF,
  parameter logic [11:0]  BG_COLOR       = 12'h000
) (
  input  logic                      clk,
  input  logic                      resetn,
  output logic [ADDRESS_LENGTH-1:0] rd_addr,
  output logic                      rd_en,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  output logic [3:0]                vga_r,
  output logic [3:0]                vga_g,
  output logic [3:0]                vga_b,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic                      frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int OFS_W   = $clog2(DATA_WIDTH);
  localparam int PIPE    = RD_LATENCY + 1;

  localparam logic [H_W-1:0] H_ACT_C  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG_C = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END_C = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0] H_LAST_C = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_C  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG_C = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END_C = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] V_LAST_C = V_W'(V_TOTAL - 1);

  logic [H_W-1:0]            h_cnt;
  logic [V_W-1:0]            v_cnt;
  logic [ADDRESS_LENGTH-1:0] word_cnt;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic [RD_LATENCY-1:0]     fetch_d;
  logic [PIPE-1:0]           de_d, hs_d, vs_d, fs_d;
  logic                      raw_active, raw_hs, raw_vs, raw_origin, fetch;
  logic                      pix_bit;
  logic [11:0]               color;

  // NOTE: combinational blocks assign every output first, so no latch can be inferred.
  always_comb begin
    raw_active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    raw_hs     = ((h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
    raw_vs     = ((v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
    raw_origin = (h_cnt == '0) && (v_cnt == '0);
    fetch      = raw_active && (h_cnt[OFS_W-1:0] == '0);
    // Read port is driven straight from the counters so memory latency lines up with PIPE.
    rd_en      = fetch & resetn;
    rd_addr    = raw_origin ? '0 : word_cnt;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      word_cnt  <= '0;
      shift_reg <= '0;
      fetch_d   <= '0;
      de_d      <= '0;
      hs_d      <= {PIPE{~SYNC_POL}};
      vs_d      <= {PIPE{~SYNC_POL}};
      fs_d      <= '0;
    end else begin
      if (h_cnt == H_LAST_C) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end

      if (fetch) word_cnt <= rd_addr + ADDRESS_LENGTH'(1);

      fetch_d[0] <= fetch;
      for (int i = 1; i < RD_LATENCY; i++) fetch_d[i] <= fetch_d[i-1];

      de_d[0] <= raw_active;
      hs_d[0] <= raw_hs;
      vs_d[0] <= raw_vs;
      fs_d[0] <= raw_origin;
      for (int i = 1; i < PIPE; i++) begin
        de_d[i] <= de_d[i-1];
        hs_d[i] <= hs_d[i-1];
        vs_d[i] <= vs_d[i-1];
        fs_d[i] <= fs_d[i-1];
      end

      // Bit 0 is the leftmost pixel of a word, so shift right after each pixel.
      if (fetch_d[RD_LATENCY-1]) shift_reg <= rd_data;
      else                       shift_reg <= shift_reg >> 1;
    end
  end

`ifdef CENTER_AXIS_EN
  localparam logic [V_W-1:0] AXIS_ROW_C = V_W'(V_ACTIVE / 2);
  logic [PIPE-1:0] axis_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      axis_d <= '0;
    end else begin
      axis_d[0] <= (v_cnt == AXIS_ROW_C);
      for (int i = 1; i < PIPE; i++) axis_d[i] <= axis_d[i-1];
    end
  end

  assign pix_bit = shift_reg[0] | axis_d[PIPE-1];
`else
  assign pix_bit = shift_reg[0];
`endif

  assign de          = de_d[PIPE-1];
  assign hsync       = hs_d[PIPE-1];
  assign vsync       = vs_d[PIPE-1];
  assign frame_start = fs_d[PIPE-1];

  // Blanking must drive black regardless of the background colour.
  assign color = de ? (pix_bit ? FG_COLOR : BG_COLOR) : 12'h000;
  assign {vga_r, vga_g, vga_b} = color;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout: reference timing model feeds an expected-pin queue
// drained PIPE cycles later; vertical timing is shortened so whole frames fit in the run.
module tb_framebuffer_scanout;

  localparam int          RDL      = 1;
  localparam int          PIPE     = RDL + 1;
  localparam int          H_ACT    = 800;
  localparam int          H_FP     = 24;
  localparam int          H_SYNC   = 72;
  localparam int          H_BP     = 128;
  localparam int          H_TOT    = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int          V_ACT    = 6;
  localparam int          V_FP     = 1;
  localparam int          V_SYNC   = 2;
  localparam int          V_BP     = 3;
  localparam int          V_TOT    = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int          WORDS    = H_ACT * V_ACT / 32;
  localparam bit          SYNC_POL = 1'b1;
  localparam logic [11:0] FG       = 12'hFFF;
  localparam logic [11:0] BG       = 12'h000;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] rgb;
  } pins_t;

  logic        clk;
  logic        resetn;
  logic [13:0] rd_addr;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, de, frame_start;

  framebuffer_scanout #(
    .DATA_WIDTH(32), .ADDRESS_LENGTH(14),
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .RD_LATENCY(RDL), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
    .de(de), .frame_start(frame_start)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory with RDL-cycle read latency; garbage when no read is issued.
  logic [31:0] mem [16384];
  logic [31:0] rd_pipe [RDL];
  always @(posedge clk) begin
    for (int i = RDL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= rd_en ? mem[rd_addr] : 32'hDEAD_BEEF;
  end
  assign rd_data = rd_pipe[RDL-1];

  // Reference raster position of the current cycle.
  int hx = 0, vy = 0;
  always @(posedge clk) begin
    if (!resetn) begin
      hx = 0; vy = 0;
    end else if (hx == H_TOT - 1) begin
      hx = 0;
      vy = (vy == V_TOT - 1) ? 0 : vy + 1;
    end else begin
      hx = hx + 1;
    end
  end

  pins_t exp_q[$];
  pins_t rst_pins, exp_p, act_p;
  int    cyc, rd_cnt, frames_seen;
  int    hs_rise, vs_rise, de_fall;
  logic  hs_prev, vs_prev, de_prev;
  logic [13:0] last_addr;

  function automatic pins_t model_pins(input int x, input int y);
    pins_t p;
    logic [31:0] w;
    logic        b;
    p.de = (x < H_ACT) && (y < V_ACT);
    p.hs = ((x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    p.vs = ((y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    p.fs = (x == 0) && (y == 0);
    w = mem[(y * H_ACT + x) / 32];
    b = w[x % 32];
`ifdef CENTER_AXIS_EN
    b = b | (y == V_ACT / 2);
`endif
    p.rgb = p.de ? (b ? FG : BG) : 12'h000;
    return p;
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      for (int i = 0; i < PIPE; i++) exp_q.push_back(rst_pins);
      cyc = 0; rd_cnt = 0; frames_seen = 0;
      hs_rise = -1; vs_rise = -1; de_fall = -1;
      hs_prev = 1'b0; vs_prev = 1'b0; de_prev = 1'b0;
    end else begin
      logic e_en;
      int   e_addr;
      e_en   = (hx < H_ACT) && (vy < V_ACT) && (hx % 32 == 0);
      e_addr = e_en ? (vy * H_ACT + hx) / 32 : 0;
      check("rd_port", {rd_en, rd_en ? rd_addr : 14'd0}, {e_en, 14'(e_addr)});

      if (hx == 0 && vy == 0) begin
        if (frames_seen > 0) begin
          check("fetches_per_frame", rd_cnt, WORDS);
          check("last_addr", last_addr, WORDS - 1);
        end
        frames_seen++;
        rd_cnt = 0;
      end
      if (rd_en) begin
        rd_cnt++;
        last_addr = rd_addr;
      end

      exp_q.push_back(model_pins(hx, vy));
      exp_p = exp_q.pop_front();
      act_p = '{de, hsync, vsync, frame_start, {vga_r, vga_g, vga_b}};
      check("pins", 32'(act_p), 32'(exp_p));

      if ((hsync == SYNC_POL) && !hs_prev) begin
        if (hs_rise >= 0) check("hs_period", cyc - hs_rise, H_TOT);
        hs_rise = cyc;
      end
      if ((hsync != SYNC_POL) && hs_prev && hs_rise >= 0) check("hs_width", cyc - hs_rise, H_SYNC);
      if ((vsync == SYNC_POL) && !vs_prev) begin
        if (vs_rise >= 0) check("vs_period", cyc - vs_rise, H_TOT * V_TOT);
        vs_rise = cyc;
      end
      if ((vsync != SYNC_POL) && vs_prev && vs_rise >= 0)
        check("vs_width", cyc - vs_rise, H_TOT * V_SYNC);
      if (de && !de_prev && de_fall >= 0) begin
        if (cyc - de_fall < H_TOT) check("de_gap_line", cyc - de_fall, H_TOT - H_ACT);
        else check("de_gap_frame", cyc - de_fall, H_TOT - H_ACT + H_TOT * (V_TOT - V_ACT));
      end
      if (!de && de_prev) de_fall = cyc;
      hs_prev = (hsync == SYNC_POL);
      vs_prev = (vsync == SYNC_POL);
      de_prev = de;
      cyc++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check(tag, {rd_en, rd_addr, vga_r, vga_g, vga_b, de, frame_start, hsync, vsync},
          {1'b0, 14'd0, 12'h000, 1'b0, 1'b0, ~SYNC_POL, ~SYNC_POL});
  endtask

  // Called just after resetn rises; walks the first cycles of the new frame.
  task automatic after_release(input string tag);
    int fs_at;
    fs_at = -1;
    for (int k = 0; k < PIPE + 4; k++) begin
      @(negedge clk);
      if (k == 0) check({tag, "_first_fetch"}, {rd_en, rd_addr}, {1'b1, 14'd0});
      if (k == PIPE) check({tag, "_pix_0_0"}, {vga_r, vga_g, vga_b}, FG);
      if (k == PIPE + 1) check({tag, "_pix_1_0"}, {vga_r, vga_g, vga_b}, BG);
      if (frame_start && fs_at < 0) fs_at = k;
    end
    check({tag, "_fs_cycle"}, fs_at, PIPE);
  endtask

  task automatic wait_pos(input int x, input int y);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (hx == x && vy == y) found = 1'b1;
    end
    check("wait_pos_reached", found, 1'b1);
  endtask

  initial begin
    resetn   = 1'b0;
    rst_pins = '{1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0, 12'h000};
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[0]  = 32'h0000_0001;
    mem[24] = 32'h8000_0000;
    mem[25] = 32'h0000_0001;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk);
    #1 resetn = 1'b1;
    after_release("boot");

    // Change memory during vertical blanking; the next frame must show it.
    wait_pos(0, V_ACT + 2);
    mem[1]  = ~mem[1];
    mem[30] = $urandom;
    mem[WORDS - 1] = 32'hA5A5_5A5A;

    // Mid-frame asynchronous reset.
    wait_pos(400, 2);
    resetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    after_release("restart");

    repeat (2 * H_TOT * V_TOT + 200) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
